// File: rtl/ts_stream_arbiter.sv
// Packet-atomic round-robin merge of N timestamp byte streams onto one AXI-S output.
// Each forwarded packet is prefixed with a header byte {HDR_TAG, source index}.
module ts_stream_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned SRC_BITS  = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  parameter logic [3:0]  HDR_TAG   = 4'hA,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_SRC-1:0]       i_src_en,
  input  logic [8*N_SRC-1:0]     i_s_axis_tdata,
  input  logic [N_SRC-1:0]       i_s_axis_tvalid,
  output logic [N_SRC-1:0]       o_s_axis_tready,
  input  logic [N_SRC-1:0]       i_s_axis_tlast,
  output logic [7:0]             o_m_axis_tdata,
  output logic                   o_m_axis_tkeep,
  output logic                   o_m_axis_tvalid,
  input  logic                   i_m_axis_tready,
  output logic                   o_m_axis_tlast,
  output logic [SRC_BITS-1:0]    o_grant,
  output logic                   o_busy,
  output logic [CNT_WIDTH-1:0]   o_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_e;

  localparam logic [SRC_BITS-1:0] PTR_RST = SRC_BITS'(N_SRC - 1);

  state_e                 state_q, state_d;
  logic [SRC_BITS-1:0]    grant_q, grant_d;
  logic [SRC_BITS-1:0]    ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [N_SRC-1:0]       elig;
  logic                   found;
  logic [SRC_BITS-1:0]    pick;
  logic [7:0]             g_data;
  logic                   g_valid;
  logic                   g_last;

  assign elig = i_s_axis_tvalid & i_src_en;

  // Two passes replace a modulo search: first above the pointer, then wrap to the lowest.
  always_comb begin : rr_pick
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!found && elig[k] && (SRC_BITS'(k) > ptr_q)) begin
        found = 1'b1;
        pick  = SRC_BITS'(k);
      end
    end
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!found && elig[k]) begin
        found = 1'b1;
        pick  = SRC_BITS'(k);
      end
    end
  end

  always_comb begin : grant_mux
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (SRC_BITS'(k) == grant_q) begin
        g_data  = i_s_axis_tdata[8*k +: 8];
        g_valid = i_s_axis_tvalid[k];
        g_last  = i_s_axis_tlast[k];
      end
    end
  end

  always_comb begin : fsm_next
    state_d         = state_q;
    grant_d         = grant_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    o_m_axis_tdata  = '0;
    o_m_axis_tvalid = 1'b0;
    o_m_axis_tlast  = 1'b0;
    o_s_axis_tready = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          ptr_d   = pick;
          state_d = HDR;
        end
      end
      HDR: begin
        o_m_axis_tdata  = {HDR_TAG, 4'(grant_q)};
        o_m_axis_tvalid = 1'b1;
        if (i_m_axis_tready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        o_m_axis_tdata  = g_data;
        o_m_axis_tvalid = g_valid;
        o_m_axis_tlast  = g_last;
        for (int unsigned k = 0; k < N_SRC; k++) begin
          if (SRC_BITS'(k) == grant_q) o_s_axis_tready[k] = i_m_axis_tready;
        end
        if (g_valid && g_last && i_m_axis_tready) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_m_axis_tkeep = 1'b1;
  assign o_grant        = grant_q;
  assign o_busy         = (state_q != IDLE);
  assign o_pkt_cnt      = cnt_q;

endmodule
